// File: rtl/game_flow_controller.sv
// Game sequencer: title -> play <-> pause -> game over -> title.
// Owns lives, level, the frame-timed pause/gameover counter and the newLevel reload pulse.
module game_flow_controller #(
  parameter int LIVES_INIT      = 3,
  parameter int NUM_LEVELS      = 4,
  parameter int PAUSE_FRAMES    = 60,
  parameter int GAMEOVER_FRAMES = 180
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       spaceKey,
  input  logic       playerHit,
  input  logic       levelCleared,
  output logic [1:0] gameState,
  output logic [2:0] lives,
  output logic [2:0] level,
  output logic       newLevel,
  output logic       gameWon
);

  localparam int CMAX = (PAUSE_FRAMES > GAMEOVER_FRAMES) ? PAUSE_FRAMES : GAMEOVER_FRAMES;
  localparam int CW   = (CMAX < 1) ? 1 : $clog2(CMAX + 1);

  localparam logic [CW-1:0] PAUSE_LAST = CW'(PAUSE_FRAMES - 1);
  localparam logic [CW-1:0] GO_LIMIT   = CW'(GAMEOVER_FRAMES);
  localparam logic [2:0]    LIVES_LD   = 3'(LIVES_INIT);
  localparam logic [2:0]    LAST_LVL   = 3'(NUM_LEVELS - 1);

  typedef enum logic [1:0] {
    TITLE    = 2'd0,
    PLAY     = 2'd1,
    GAMEOVER = 2'd2,
    PAUSE    = 2'd3
  } state_t;

  state_t        state, stateNxt;
  logic [2:0]    livesNxt, levelNxt;
  logic          newLevelNxt, gameWonNxt;
  logic [CW-1:0] cnt, cntNxt;
  logic          spacePrev, spaceRise;

  assign spaceRise = spaceKey & ~spacePrev;
  assign gameState = state;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= TITLE;
      lives     <= LIVES_LD;
      level     <= 3'd0;
      newLevel  <= 1'b0;
      gameWon   <= 1'b0;
      cnt       <= '0;
      // Treat the key as already down so a press held through reset is not an edge
      spacePrev <= 1'b1;
    end else begin
      state     <= stateNxt;
      lives     <= livesNxt;
      level     <= levelNxt;
      newLevel  <= newLevelNxt;
      gameWon   <= gameWonNxt;
      cnt       <= cntNxt;
      spacePrev <= spaceKey;
    end
  end

  always_comb begin
    stateNxt    = state;
    livesNxt    = lives;
    levelNxt    = level;
    newLevelNxt = 1'b0;
    gameWonNxt  = gameWon;
    cntNxt      = cnt;
    unique case (state)
      TITLE: begin
        if (spaceRise) begin
          stateNxt    = PLAY;
          livesNxt    = LIVES_LD;
          levelNxt    = 3'd0;
          gameWonNxt  = 1'b0;
          newLevelNxt = 1'b1;
          cntNxt      = '0;
        end
      end
      PLAY: begin
        // A hit takes priority; a simultaneous clear is dropped
        if (playerHit) begin
          cntNxt = '0;
          if (lives <= 3'd1) begin
            livesNxt   = 3'd0;
            stateNxt   = GAMEOVER;
            gameWonNxt = 1'b0;
          end else begin
            livesNxt = lives - 3'd1;
            stateNxt = PAUSE;
          end
        end else if (levelCleared) begin
          cntNxt = '0;
          if (level >= LAST_LVL) begin
            stateNxt   = GAMEOVER;
            gameWonNxt = 1'b1;
          end else begin
            levelNxt = level + 3'd1;
            stateNxt = PAUSE;
          end
        end
      end
      PAUSE: begin
        if (startOfFrame) begin
          if (cnt >= PAUSE_LAST) begin
            stateNxt    = PLAY;
            cntNxt      = '0;
            newLevelNxt = 1'b1;
          end else begin
            cntNxt = cnt + CW'(1);
          end
        end
      end
      GAMEOVER: begin
        if (spaceRise && cnt == GO_LIMIT) begin
          stateNxt   = TITLE;
          cntNxt     = '0;
          gameWonNxt = 1'b0;
        end else if (startOfFrame && cnt < GO_LIMIT) begin
          cntNxt = cnt + CW'(1);
        end
      end
      default: stateNxt = TITLE;
    endcase
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed-vector bench for game_flow_controller with default parameters.
// Each vector is one clock: inputs driven at negedge, outputs checked #1 after posedge.
module tb_game_flow_controller;

  logic       clk = 1'b0;
  logic       resetN, startOfFrame, spaceKey, playerHit, levelCleared;
  logic [1:0] gameState;
  logic [2:0] lives, level;
  logic       newLevel, gameWon;

  int nVec = 0;
  int nErr = 0;

  localparam logic [1:0] T = 2'd0, P = 2'd1, G = 2'd2, Z = 2'd3;

  typedef struct {
    logic       rstN, sof, sp, hit, clr;
    logic [1:0] st;
    logic [2:0] lv, lvl;
    logic       nl, won;
  } vec_t;

  game_flow_controller dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .spaceKey(spaceKey),
    .playerHit(playerHit), .levelCleared(levelCleared), .gameState(gameState),
    .lives(lives), .level(level), .newLevel(newLevel), .gameWon(gameWon)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(logic sof, logic sp, logic hit, logic clr, logic [1:0] st,
                             logic [2:0] lv, logic [2:0] lvl, logic nl, logic won);
    vec_t r;
    r.rstN = 1'b1; r.sof = sof; r.sp = sp; r.hit = hit; r.clr = clr;
    r.st = st; r.lv = lv; r.lvl = lvl; r.nl = nl; r.won = won;
    return r;
  endfunction

  task automatic check(string nm, logic [1:0] st, logic [2:0] lv, logic [2:0] lvl,
                       logic nl, logic won);
    nVec++;
    if ({gameState, lives, level, newLevel, gameWon} !== {st, lv, lvl, nl, won}) begin
      nErr++;
      $display("FAIL %s: got st=%0d lives=%0d level=%0d nl=%0b won=%0b, want st=%0d lives=%0d level=%0d nl=%0b won=%0b",
               nm, gameState, lives, level, newLevel, gameWon, st, lv, lvl, nl, won);
    end
  endtask

  task automatic apply(vec_t x, string nm);
    @(negedge clk);
    resetN = x.rstN; startOfFrame = x.sof; spaceKey = x.sp;
    playerHit = x.hit; levelCleared = x.clr;
    @(posedge clk);
    #1;
    check(nm, x.st, x.lv, x.lvl, x.nl, x.won);
  endtask

  // Full pause: 59 frames (interleaved with idle cycles) stay in PAUSE, the 60th resumes play
  task automatic runPause(logic [2:0] lv, logic [2:0] lvl);
    for (int i = 0; i < 59; i++) begin
      apply(v(0, 0, 0, 0, Z, lv, lvl, 0, 0), "pause_idle");
      apply(v(1, 0, 0, 0, Z, lv, lvl, 0, 0), "pause_frame");
    end
    apply(v(1, 0, 0, 0, P, lv, lvl, 1, 0), "pause_exit");
    apply(v(0, 0, 0, 0, P, lv, lvl, 0, 0), "newlevel_once");
  endtask

  task automatic frames(int n, logic [1:0] st, logic [2:0] lv, logic [2:0] lvl, logic won,
                        string nm);
    for (int i = 0; i < n; i++) apply(v(1, 0, 0, 0, st, lv, lvl, 0, won), nm);
  endtask

  vec_t startTab[6];
  vec_t clearTab[5];

  initial begin
    startTab[0] = v(0, 1, 0, 0, T, 3, 0, 0, 0);  // key held through reset
    startTab[1] = v(0, 0, 0, 0, T, 3, 0, 0, 0);  // release
    startTab[2] = v(0, 1, 0, 0, P, 3, 0, 1, 0);  // press -> play
    startTab[3] = v(0, 1, 1, 1, Z, 2, 0, 0, 0);  // hit wins over clear
    startTab[4] = v(0, 1, 1, 1, Z, 2, 0, 0, 0);  // ignored in pause
    startTab[5] = v(0, 0, 0, 0, Z, 2, 0, 0, 0);
    clearTab[0] = v(0, 0, 0, 1, Z, 2, 1, 0, 0);
    clearTab[1] = v(0, 0, 0, 1, Z, 2, 2, 0, 0);
    clearTab[2] = v(0, 0, 0, 1, Z, 2, 3, 0, 0);
    clearTab[3] = v(0, 0, 1, 0, Z, 1, 3, 0, 0);
    clearTab[4] = v(0, 0, 1, 0, G, 0, 3, 0, 0);  // last life

    resetN = 1'b0; startOfFrame = 1'b0; spaceKey = 1'b1; playerHit = 1'b0; levelCleared = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset", T, 3, 0, 0, 0);

    for (int i = 0; i < 6; i++) apply(startTab[i], "start_tab");
    runPause(2, 0);
    for (int i = 0; i < 4; i++) begin
      apply(clearTab[i], "clear_tab");
      runPause(clearTab[i].lv, clearTab[i].lvl);
    end
    apply(clearTab[4], "hit_gameover");

    // GAMEOVER space gating
    frames(100, G, 0, 3, 0, "go_count");
    apply(v(0, 1, 0, 0, G, 0, 3, 0, 0), "go_space_early100");
    apply(v(0, 0, 0, 0, G, 0, 3, 0, 0), "go_release");
    frames(79, G, 0, 3, 0, "go_count");
    apply(v(0, 1, 0, 0, G, 0, 3, 0, 0), "go_space_early179");
    apply(v(1, 0, 0, 0, G, 0, 3, 0, 0), "go_frame180");
    frames(3, G, 0, 3, 0, "go_saturate");
    apply(v(0, 1, 0, 0, T, 0, 3, 0, 0), "go_to_title");

    // Second game: clear every level and win
    apply(v(0, 0, 0, 0, T, 0, 3, 0, 0), "title_hold");
    apply(v(0, 1, 1, 1, P, 3, 0, 1, 0), "restart");
    for (int l = 1; l < 4; l++) begin
      apply(v(0, 0, 0, 1, Z, 3, 3'(l), 0, 0), "clear_adv");
      runPause(3, 3'(l));
    end
    apply(v(0, 0, 0, 1, G, 3, 3, 0, 1), "clear_last_win");
    frames(180, G, 3, 3, 1, "win_count");
    apply(v(0, 1, 0, 0, T, 3, 3, 0, 0), "win_to_title");

    // Third game: asynchronous reset in the middle of a pause
    apply(v(0, 0, 0, 0, T, 3, 3, 0, 0), "title_hold2");
    apply(v(0, 1, 0, 0, P, 3, 0, 1, 0), "restart2");
    apply(v(0, 1, 1, 0, Z, 2, 0, 0, 0), "hit_pause");
    frames(10, Z, 2, 0, 0, "pause_frame");
    @(negedge clk);
    #2 resetN = 1'b0;
    #1 check("async_reset", T, 3, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 check("reset_hold", T, 3, 0, 0, 0);
    apply(v(1, 1, 0, 0, T, 3, 0, 0, 0), "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
